// File: rtl/button_debouncer_if.sv
// Pushbutton debouncer signal bundle: raw button in, debounced level and edge strobes out.
interface button_debouncer_if;
   logic BTN;
   logic PRESS;
   logic PRESS_PULSE;
   logic RELEASE_PULSE;

   modport master (
      output BTN,
      input  PRESS,
      input  PRESS_PULSE,
      input  RELEASE_PULSE
   );

   modport slave (
      input  BTN,
      output PRESS,
      output PRESS_PULSE,
      output RELEASE_PULSE
   );
endinterface

// File: rtl/button_debouncer.sv
// Synchronizes a raw pushbutton and accepts a level change only after it has been
// stable for DEBOUNCE_CYCLES clocks; emits registered level plus press/release strobes.
module button_debouncer #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic              CLK,
   input  logic              reset_n,
   button_debouncer_if.slave bus
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   localparam logic [1:0] ST_IDLE      = 2'd0;
   localparam logic [1:0] ST_WAIT_HIGH = 2'd1;
   localparam logic [1:0] ST_HIGH      = 2'd2;
   localparam logic [1:0] ST_WAIT_LOW  = 2'd3;

   logic             sync1_q;
   logic             sync2_q;
   logic [1:0]       state_q;
   logic [1:0]       state_d;
   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;
   logic             press_q;
   logic             press_d;
   logic             pressPulse_q;
   logic             pressPulse_d;
   logic             releasePulse_q;
   logic             releasePulse_d;

   // Two-flop synchronizer; only sync2_q is trusted downstream.
   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
      end else begin
         sync1_q <= bus.BTN;
         sync2_q <= sync1_q;
      end
   end

   always_comb begin
      state_d        = state_q;
      count_d        = count_q;
      pressPulse_d   = 1'b0;
      releasePulse_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (sync2_q) begin
               state_d = ST_WAIT_HIGH;
               count_d = '0;
            end
         end
         ST_WAIT_HIGH: begin
            if (!sync2_q) begin
               state_d = ST_IDLE;
               count_d = '0;
            end else if (count_q == CNT_MAX) begin
               state_d      = ST_HIGH;
               count_d      = '0;
               pressPulse_d = 1'b1;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         ST_HIGH: begin
            if (!sync2_q) begin
               state_d = ST_WAIT_LOW;
               count_d = '0;
            end
         end
         ST_WAIT_LOW: begin
            if (sync2_q) begin
               state_d = ST_HIGH;
               count_d = '0;
            end else if (count_q == CNT_MAX) begin
               state_d        = ST_IDLE;
               count_d        = '0;
               releasePulse_d = 1'b1;
            end else begin
               count_d = count_q + CNT_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
      // Registered level follows the state being entered, so PRESS rises with the strobe.
      press_d = (state_d == ST_HIGH) || (state_d == ST_WAIT_LOW);
   end

   always_ff @(posedge CLK or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= ST_IDLE;
         count_q        <= '0;
         press_q        <= 1'b0;
         pressPulse_q   <= 1'b0;
         releasePulse_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         count_q        <= count_d;
         press_q        <= press_d;
         pressPulse_q   <= pressPulse_d;
         releasePulse_q <= releasePulse_d;
      end
   end

   assign bus.PRESS         = press_q;
   assign bus.PRESS_PULSE   = pressPulse_q;
   assign bus.RELEASE_PULSE = releasePulse_q;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4 (accept after edge 7).
module tb_button_debouncer;

   logic CLK;
   logic reset_n;

   button_debouncer_if dbgIf ();

   button_debouncer #(
      .DEBOUNCE_CYCLES(4)
   ) dut (
      .CLK    (CLK),
      .reset_n(reset_n),
      .bus    (dbgIf)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int checks;
   int failures;
   int pressPulseCount;
   int releasePulseCount;
   int pressHighCycles;
   int pressLowCycles;
   int bothCount;
   int eventCount;
   logic [7:0] eventSeq;

   // Pulse/level bookkeeping sampled mid-cycle, away from the active edge.
   always @(negedge CLK) begin
      if (dbgIf.PRESS_PULSE) begin
         pressPulseCount = pressPulseCount + 1;
         eventSeq        = {eventSeq[6:0], 1'b1};
         eventCount      = eventCount + 1;
      end
      if (dbgIf.RELEASE_PULSE) begin
         releasePulseCount = releasePulseCount + 1;
         eventSeq          = {eventSeq[6:0], 1'b0};
         eventCount        = eventCount + 1;
      end
      if (dbgIf.PRESS_PULSE && dbgIf.RELEASE_PULSE) bothCount = bothCount + 1;
      if (dbgIf.PRESS) pressHighCycles = pressHighCycles + 1;
      else             pressLowCycles  = pressLowCycles + 1;
   end

   task automatic checkOutput(input string tag, input int observed, input int expected);
      checks = checks + 1;
      if (observed !== expected) begin
         failures = failures + 1;
         $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
      end
   endtask

   task automatic waitEdges(input int n);
      repeat (n) begin
         @(posedge CLK);
         @(negedge CLK);
      end
   endtask

   task automatic applyStimulus(input logic btnVal, input int cycles);
      dbgIf.BTN = btnVal;
      waitEdges(cycles);
   endtask

   int ppBase;
   int rpBase;
   int hiBase;
   int loBase;

   initial begin
      checks            = 0;
      failures          = 0;
      pressPulseCount   = 0;
      releasePulseCount = 0;
      pressHighCycles   = 0;
      pressLowCycles    = 0;
      bothCount         = 0;
      eventCount        = 0;
      eventSeq          = 8'h00;

      // Test 1: reset held with button down, then re-debounce after release
      reset_n   = 1'b0;
      dbgIf.BTN = 1'b1;
      waitEdges(3);
      checkOutput("t1_rst_press", int'(dbgIf.PRESS), 0);
      checkOutput("t1_rst_ppulse", int'(dbgIf.PRESS_PULSE), 0);
      checkOutput("t1_rst_rpulse", int'(dbgIf.RELEASE_PULSE), 0);
      reset_n = 1'b1;
      waitEdges(6);
      checkOutput("t1_press_edge6", int'(dbgIf.PRESS), 0);
      checkOutput("t1_ppulse_edge6", int'(dbgIf.PRESS_PULSE), 0);
      waitEdges(1);
      checkOutput("t1_press_edge7", int'(dbgIf.PRESS), 1);
      checkOutput("t1_ppulse_edge7", int'(dbgIf.PRESS_PULSE), 1);
      waitEdges(1);
      checkOutput("t1_ppulse_edge8", int'(dbgIf.PRESS_PULSE), 0);
      checkOutput("t1_press_edge8", int'(dbgIf.PRESS), 1);

      // Test 2: clean press from idle
      applyStimulus(1'b0, 12);
      checkOutput("t2_idle_press", int'(dbgIf.PRESS), 0);
      ppBase = pressPulseCount;
      applyStimulus(1'b1, 6);
      checkOutput("t2_press_edge6", int'(dbgIf.PRESS), 0);
      waitEdges(1);
      checkOutput("t2_press_edge7", int'(dbgIf.PRESS), 1);
      checkOutput("t2_ppulse_edge7", int'(dbgIf.PRESS_PULSE), 1);
      waitEdges(1);
      checkOutput("t2_ppulse_edge8", int'(dbgIf.PRESS_PULSE), 0);
      waitEdges(12);
      checkOutput("t2_ppulse_count", pressPulseCount - ppBase, 1);
      checkOutput("t2_press_held", int'(dbgIf.PRESS), 1);

      // Test 3: short high bursts never accepted
      applyStimulus(1'b0, 10);
      checkOutput("t3_start_low", int'(dbgIf.PRESS), 0);
      ppBase = pressPulseCount;
      hiBase = pressHighCycles;
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 3);
         applyStimulus(1'b0, 2);
      end
      applyStimulus(1'b0, 10);
      checkOutput("t3_press_low", int'(dbgIf.PRESS), 0);
      checkOutput("t3_high_cycles", pressHighCycles - hiBase, 0);
      checkOutput("t3_ppulse_count", pressPulseCount - ppBase, 0);

      // Test 4: short release glitch ignored, then real release
      applyStimulus(1'b1, 10);
      checkOutput("t4_pressed", int'(dbgIf.PRESS), 1);
      ppBase = pressPulseCount;
      rpBase = releasePulseCount;
      loBase = pressLowCycles;
      applyStimulus(1'b0, 3);
      applyStimulus(1'b1, 6);
      checkOutput("t4_glitch_press", int'(dbgIf.PRESS), 1);
      checkOutput("t4_glitch_low_cycles", pressLowCycles - loBase, 0);
      checkOutput("t4_glitch_pulses", (pressPulseCount - ppBase) + (releasePulseCount - rpBase), 0);
      applyStimulus(1'b0, 6);
      checkOutput("t4_rel_edge6", int'(dbgIf.PRESS), 1);
      waitEdges(1);
      checkOutput("t4_rel_edge7_press", int'(dbgIf.PRESS), 0);
      checkOutput("t4_rel_edge7_rpulse", int'(dbgIf.RELEASE_PULSE), 1);
      checkOutput("t4_rel_edge7_ppulse", int'(dbgIf.PRESS_PULSE), 0);
      waitEdges(1);
      checkOutput("t4_rpulse_edge8", int'(dbgIf.RELEASE_PULSE), 0);
      waitEdges(2);
      checkOutput("t4_rpulse_count", releasePulseCount - rpBase, 1);

      // Test 5: reset while pressed, button still held
      applyStimulus(1'b1, 10);
      checkOutput("t5_pressed", int'(dbgIf.PRESS), 1);
      reset_n = 1'b0;
      #1;
      checkOutput("t5_async_press", int'(dbgIf.PRESS), 0);
      checkOutput("t5_async_ppulse", int'(dbgIf.PRESS_PULSE), 0);
      waitEdges(2);
      reset_n = 1'b1;
      waitEdges(6);
      checkOutput("t5_press_edge6", int'(dbgIf.PRESS), 0);
      waitEdges(1);
      checkOutput("t5_press_edge7", int'(dbgIf.PRESS), 1);
      checkOutput("t5_ppulse_edge7", int'(dbgIf.PRESS_PULSE), 1);

      // Test 6: two back-to-back presses alternate press/release strobes
      applyStimulus(1'b0, 10);
      ppBase     = pressPulseCount;
      rpBase     = releasePulseCount;
      eventCount = 0;
      eventSeq   = 8'h00;
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 8);
      applyStimulus(1'b1, 10);
      applyStimulus(1'b0, 10);
      checkOutput("t6_ppulse_count", pressPulseCount - ppBase, 2);
      checkOutput("t6_rpulse_count", releasePulseCount - rpBase, 2);
      checkOutput("t6_event_count", eventCount, 4);
      checkOutput("t6_event_order", int'(eventSeq[3:0]), 4'b1010);
      checkOutput("t6_both_pulses", bothCount, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
